// File: rtl/l1_mem_arbiter.sv
// Round-robin arbiter sharing one system-memory cache-line port between L1 I$ fills and L1 D$ fills/write-backs.
// One transaction outstanding; the memory acknowledge is routed combinationally back to the owning cache.
module l1_mem_arbiter #(
    parameter int A_SZ   = 32,
    parameter int CL_LEN = 32,
    parameter int CL_SZ  = 5
) (
    input  logic                     clk_in,
    input  logic                     reset_in,
    input  logic                     ic_req_valid,
    output logic                     ic_req_rdy,
    input  logic [A_SZ-CL_SZ-1:0]    ic_req_addr,
    output logic                     ic_ack_valid,
    input  logic                     ic_ack_rdy,
    output logic [CL_LEN*8-1:0]      ic_ack_data,
    input  logic                     dc_req_valid,
    output logic                     dc_req_rdy,
    input  logic [A_SZ-CL_SZ-1:0]    dc_req_addr,
    input  logic                     dc_req_rw,
    input  logic [CL_LEN*8-1:0]      dc_req_wr_data,
    output logic                     dc_ack_valid,
    input  logic                     dc_ack_rdy,
    output logic [CL_LEN*8-1:0]      dc_ack_data,
    output logic                     mem_req_valid,
    input  logic                     mem_req_rdy,
    output logic [A_SZ-CL_SZ-1:0]    mem_req_addr,
    output logic                     mem_req_rw,
    output logic [CL_LEN*8-1:0]      mem_req_wr_data,
    input  logic                     mem_ack_valid,
    output logic                     mem_ack_rdy,
    input  logic [CL_LEN*8-1:0]      mem_ack_data
);

    localparam int CLA_SZ = A_SZ - CL_SZ;
    localparam int DW     = CL_LEN * 8;

    typedef enum logic [1:0] {ARB_IDLE, ARB_REQ, ARB_ACK} arb_state_t;
    typedef enum logic {OWN_IC, OWN_DC} owner_t;

    arb_state_t state;
    owner_t     owner;
    owner_t     last_grant;

    logic grant_ic;
    logic grant_dc;
    logic in_ack;
    logic ic_sel;
    logic dc_sel;

    // A tie goes to whichever cache did not win the previous transaction.
    always_comb begin
        grant_ic = 1'b0;
        grant_dc = 1'b0;
        if (!reset_in && state == ARB_IDLE) begin
            grant_ic = ic_req_valid && (!dc_req_valid || last_grant == OWN_DC);
            grant_dc = dc_req_valid && (!ic_req_valid || last_grant == OWN_IC);
        end
    end

    assign ic_req_rdy = grant_ic;
    assign dc_req_rdy = grant_dc;

    assign in_ack = (state == ARB_ACK) && !reset_in;
    assign ic_sel = in_ack && (owner == OWN_IC);
    assign dc_sel = in_ack && (owner == OWN_DC);

    assign ic_ack_valid = ic_sel && mem_ack_valid;
    assign dc_ack_valid = dc_sel && mem_ack_valid;
    assign ic_ack_data  = ic_sel ? mem_ack_data : {DW{1'b0}};
    assign dc_ack_data  = dc_sel ? mem_ack_data : {DW{1'b0}};
    assign mem_ack_rdy  = (ic_sel && ic_ack_rdy) || (dc_sel && dc_ack_rdy);

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            state           <= ARB_IDLE;
            owner           <= OWN_IC;
            last_grant      <= OWN_IC;
            mem_req_valid   <= 1'b0;
            mem_req_addr    <= {CLA_SZ{1'b0}};
            mem_req_rw      <= 1'b0;
            mem_req_wr_data <= {DW{1'b0}};
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (grant_ic) begin
                        owner           <= OWN_IC;
                        mem_req_addr    <= ic_req_addr;
                        mem_req_rw      <= 1'b0;
                        mem_req_wr_data <= {DW{1'b0}};
                        mem_req_valid   <= 1'b1;
                        state           <= ARB_REQ;
                    end else if (grant_dc) begin
                        owner           <= OWN_DC;
                        mem_req_addr    <= dc_req_addr;
                        mem_req_rw      <= dc_req_rw;
                        mem_req_wr_data <= dc_req_wr_data;
                        mem_req_valid   <= 1'b1;
                        state           <= ARB_REQ;
                    end
                end
                ARB_REQ: begin
                    if (mem_req_rdy) begin
                        mem_req_valid <= 1'b0;
                        state         <= ARB_ACK;
                    end
                end
                ARB_ACK: begin
                    if (mem_ack_valid && mem_ack_rdy) begin
                        last_grant <= owner;
                        state      <= ARB_IDLE;
                    end
                end
                default: begin
                    mem_req_valid <= 1'b0;
                    state         <= ARB_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_l1_mem_arbiter.sv
// Self-checking bench for l1_mem_arbiter: directed scenarios plus randomized traffic against a transaction-level model.
module tb_l1_mem_arbiter;

    localparam int CLA = 27;
    localparam int DW  = 256;

    logic           clk_in = 1'b0;
    logic           reset_in;
    logic           ic_req_valid, ic_req_rdy, ic_ack_valid, ic_ack_rdy;
    logic [CLA-1:0] ic_req_addr;
    logic [DW-1:0]  ic_ack_data;
    logic           dc_req_valid, dc_req_rdy, dc_req_rw, dc_ack_valid, dc_ack_rdy;
    logic [CLA-1:0] dc_req_addr;
    logic [DW-1:0]  dc_req_wr_data, dc_ack_data;
    logic           mem_req_valid, mem_req_rdy, mem_req_rw, mem_ack_valid, mem_ack_rdy;
    logic [CLA-1:0] mem_req_addr;
    logic [DW-1:0]  mem_req_wr_data, mem_ack_data;

    int total = 0;
    int bad   = 0;
    bit check_en = 1'b0;

    l1_mem_arbiter dut (
        .clk_in(clk_in), .reset_in(reset_in),
        .ic_req_valid(ic_req_valid), .ic_req_rdy(ic_req_rdy), .ic_req_addr(ic_req_addr),
        .ic_ack_valid(ic_ack_valid), .ic_ack_rdy(ic_ack_rdy), .ic_ack_data(ic_ack_data),
        .dc_req_valid(dc_req_valid), .dc_req_rdy(dc_req_rdy), .dc_req_addr(dc_req_addr),
        .dc_req_rw(dc_req_rw), .dc_req_wr_data(dc_req_wr_data),
        .dc_ack_valid(dc_ack_valid), .dc_ack_rdy(dc_ack_rdy), .dc_ack_data(dc_ack_data),
        .mem_req_valid(mem_req_valid), .mem_req_rdy(mem_req_rdy), .mem_req_addr(mem_req_addr),
        .mem_req_rw(mem_req_rw), .mem_req_wr_data(mem_req_wr_data),
        .mem_ack_valid(mem_ack_valid), .mem_ack_rdy(mem_ack_rdy), .mem_ack_data(mem_ack_data)
    );

    always #5 clk_in = ~clk_in;

    // Transaction-level model: at most one pending transaction, which is either waiting
    // for memory to take it or waiting for its completion.
    bit             m_busy, m_sent, m_owner_dc, m_last_dc;
    logic [CLA-1:0] m_addr;
    bit             m_rw;
    logic [DW-1:0]  m_wdata;
    bit             acc_ic, acc_dc;
    int             ic_acks = 0, dc_acks = 0;
    bit             grants[$];

    function automatic bit exp_ic_rdy();
        return !reset_in && !m_busy && ic_req_valid && (!dc_req_valid || m_last_dc);
    endfunction

    function automatic bit exp_dc_rdy();
        return !reset_in && !m_busy && dc_req_valid && (!ic_req_valid || !m_last_dc);
    endfunction

    function automatic bit exp_in_ack();
        return !reset_in && m_busy && m_sent;
    endfunction

    function automatic bit exp_mem_ack_rdy();
        return exp_in_ack() && (m_owner_dc ? dc_ack_rdy : ic_ack_rdy);
    endfunction

    function automatic logic [DW-1:0] rand_line();
        logic [DW-1:0] v;
        for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    always @(posedge clk_in) begin
        acc_ic <= 1'b0;
        acc_dc <= 1'b0;
        if (reset_in) begin
            m_busy <= 1'b0; m_sent <= 1'b0; m_owner_dc <= 1'b0; m_last_dc <= 1'b0;
            m_addr <= '0; m_rw <= 1'b0; m_wdata <= '0;
        end else if (!m_busy) begin
            if (exp_ic_rdy()) begin
                m_busy <= 1'b1; m_sent <= 1'b0; m_owner_dc <= 1'b0;
                m_addr <= ic_req_addr; m_rw <= 1'b0; m_wdata <= '0;
                acc_ic <= 1'b1; grants.push_back(1'b0);
            end else if (exp_dc_rdy()) begin
                m_busy <= 1'b1; m_sent <= 1'b0; m_owner_dc <= 1'b1;
                m_addr <= dc_req_addr; m_rw <= dc_req_rw; m_wdata <= dc_req_wr_data;
                acc_dc <= 1'b1; grants.push_back(1'b1);
            end
        end else if (!m_sent) begin
            if (mem_req_rdy) m_sent <= 1'b1;
        end else if (mem_ack_valid && exp_mem_ack_rdy()) begin
            m_busy    <= 1'b0;
            m_last_dc <= m_owner_dc;
            if (m_owner_dc) dc_acks <= dc_acks + 1;
            else            ic_acks <= ic_acks + 1;
        end
    end

    task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk_in) begin
        if (check_en) begin
            checkOutput("ic_req_rdy", ic_req_rdy, exp_ic_rdy());
            checkOutput("dc_req_rdy", dc_req_rdy, exp_dc_rdy());
            checkOutput("mem_req_valid", mem_req_valid, m_busy && !m_sent);
            checkOutput("mem_ack_rdy", mem_ack_rdy, exp_mem_ack_rdy());
            checkOutput("ic_ack_valid", ic_ack_valid, exp_in_ack() && !m_owner_dc && mem_ack_valid);
            checkOutput("dc_ack_valid", dc_ack_valid, exp_in_ack() && m_owner_dc && mem_ack_valid);
            if (exp_in_ack()) begin
                checkOutput("ic_ack_data", ic_ack_data, m_owner_dc ? '0 : mem_ack_data);
                checkOutput("dc_ack_data", dc_ack_data, m_owner_dc ? mem_ack_data : '0);
            end
            if (m_busy && !m_sent) begin
                checkOutput("mem_req_addr", mem_req_addr, m_addr);
                checkOutput("mem_req_rw", mem_req_rw, m_rw);
                checkOutput("mem_req_wr_data", mem_req_wr_data, m_wdata);
            end
        end
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic idleInputs();
        ic_req_valid = 0; ic_req_addr = '0; ic_ack_rdy = 0;
        dc_req_valid = 0; dc_req_addr = '0; dc_req_rw = 0; dc_req_wr_data = '0; dc_ack_rdy = 0;
        mem_req_rdy = 0; mem_ack_valid = 0; mem_ack_data = '0;
    endtask

    task automatic waitIdle(input string name);
        int c;
        mem_req_rdy = 1; mem_ack_valid = 1; ic_ack_rdy = 1; dc_ack_rdy = 1;
        for (c = 0; c < 20 && m_busy; c++) tick();
        mem_ack_valid = 0;
        checkOutput(name, m_busy, 1'b0);
    endtask

    // Random traffic: requesters hold a request until it is accepted, then maybe issue another.
    task automatic applyStimulus(input int cycles);
        for (int n = 0; n < cycles; n++) begin
            reset_in = ($urandom_range(0, 299) == 0);
            if (!ic_req_valid || acc_ic) begin
                ic_req_valid = $urandom_range(0, 1);
                ic_req_addr  = CLA'($urandom);
            end
            if (!dc_req_valid || acc_dc) begin
                dc_req_valid   = $urandom_range(0, 1);
                dc_req_addr    = CLA'($urandom);
                dc_req_rw      = $urandom_range(0, 1);
                dc_req_wr_data = rand_line();
            end
            mem_req_rdy   = ($urandom_range(0, 2) != 0);
            mem_ack_valid = $urandom_range(0, 1);
            mem_ack_data  = rand_line();
            ic_ack_rdy    = $urandom_range(0, 1);
            dc_ack_rdy    = $urandom_range(0, 1);
            tick();
        end
        reset_in = 0;
    endtask

    initial begin
        int c;
        int acks_before;
        logic [CLA-1:0] held_addr;

        // Reset held for two cycles with no traffic.
        idleInputs();
        reset_in = 1;
        tick();
        check_en = 1'b1;
        tick();
        checkOutput("rst_mem_req_valid", mem_req_valid, 1'b0);
        checkOutput("rst_mem_req_addr", mem_req_addr, '0);
        checkOutput("rst_mem_req_wr_data", mem_req_wr_data, '0);
        checkOutput("rst_mem_ack_rdy", mem_ack_rdy, 1'b0);
        checkOutput("rst_ic_ack_valid", ic_ack_valid, 1'b0);
        reset_in = 0;
        tick(); tick();
        checkOutput("post_rst_mem_req_valid", mem_req_valid, 1'b0);

        // Lone I$ read.
        ic_req_valid = 1; ic_req_addr = 27'h1234567; mem_req_rdy = 1; ic_ack_rdy = 1;
        #1 checkOutput("t2_ic_req_rdy", ic_req_rdy, 1'b1);
        tick();
        ic_req_valid = 0;
        checkOutput("t2_mem_req_valid", mem_req_valid, 1'b1);
        checkOutput("t2_mem_req_addr", mem_req_addr, 27'h1234567);
        checkOutput("t2_mem_req_rw", mem_req_rw, 1'b0);
        tick();
        mem_ack_valid = 1; mem_ack_data = {8{32'hA5A5A5A5}};
        #1 checkOutput("t2_ic_ack_valid", ic_ack_valid, 1'b1);
        checkOutput("t2_ic_ack_data", ic_ack_data, {8{32'hA5A5A5A5}});
        checkOutput("t2_dc_ack_valid", dc_ack_valid, 1'b0);
        tick();
        mem_ack_valid = 0;

        // Both caches requesting continuously after reset: D$ first, then strict alternation.
        reset_in = 1; tick(); reset_in = 0;
        grants.delete();
        ic_req_valid = 1; ic_req_addr = 27'h0000111;
        dc_req_valid = 1; dc_req_addr = 27'h0000222; dc_req_rw = 0;
        mem_req_rdy = 1; mem_ack_valid = 1; ic_ack_rdy = 1; dc_ack_rdy = 1;
        for (c = 0; c < 40 && grants.size() < 4; c++) tick();
        ic_req_valid = 0; dc_req_valid = 0;
        checkOutput("t3_grant_count", 32'(grants.size()), 32'd4);
        if (grants.size() >= 4) begin
            checkOutput("t3_grant0_dc", grants[0], 1'b1);
            checkOutput("t3_grant1_ic", grants[1], 1'b0);
            checkOutput("t3_grant2_dc", grants[2], 1'b1);
            checkOutput("t3_grant3_ic", grants[3], 1'b0);
        end
        waitIdle("t3_drain");
        idleInputs();

        // D$ write-back.
        dc_req_valid = 1; dc_req_addr = 27'h0ABCDEF; dc_req_rw = 1; dc_req_wr_data = {8{32'hDEADBEEF}};
        tick();
        dc_req_valid = 0;
        checkOutput("t4_mem_req_valid", mem_req_valid, 1'b1);
        checkOutput("t4_mem_req_rw", mem_req_rw, 1'b1);
        checkOutput("t4_mem_req_wr_data", mem_req_wr_data, {8{32'hDEADBEEF}});
        mem_req_rdy = 1;
        tick();
        mem_ack_valid = 1; dc_ack_rdy = 1;
        #1 checkOutput("t4_dc_ack_valid", dc_ack_valid, 1'b1);
        tick();
        mem_ack_valid = 0;
        checkOutput("t4_back_idle_ack_rdy", mem_ack_rdy, 1'b0);
        idleInputs();

        // Backpressure on both memory request and owner acknowledge.
        ic_req_valid = 1; ic_req_addr = 27'h5555555;
        tick();
        ic_req_valid = 0;
        held_addr = 27'h5555555;
        for (int i = 0; i < 5; i++) begin
            checkOutput("t5_req_held_valid", mem_req_valid, 1'b1);
            checkOutput("t5_req_held_addr", mem_req_addr, held_addr);
            tick();
        end
        mem_req_rdy = 1;
        tick();
        mem_req_rdy = 0;
        acks_before = ic_acks;
        mem_ack_valid = 1; mem_ack_data = rand_line(); ic_ack_rdy = 0;
        for (int i = 0; i < 3; i++) begin
            #1 checkOutput("t5_ack_rdy_low", mem_ack_rdy, 1'b0);
            tick();
        end
        ic_ack_rdy = 1;
        #1 checkOutput("t5_ack_rdy_high", mem_ack_rdy, 1'b1);
        tick();
        mem_ack_valid = 0;
        tick();
        checkOutput("t5_one_ack", 32'(ic_acks - acks_before), 32'd1);
        idleInputs();

        // Reset while the D$ completion is being offered.
        dc_req_valid = 1; dc_req_addr = 27'h0000333; mem_req_rdy = 1;
        tick();
        dc_req_valid = 0;
        tick();
        acks_before = dc_acks;
        mem_ack_valid = 1; dc_ack_rdy = 0;
        #1 checkOutput("t6_pre_rst_ack_valid", dc_ack_valid, 1'b1);
        reset_in = 1;
        #1 checkOutput("t6_rst_ack_valid", dc_ack_valid, 1'b0);
        tick();
        reset_in = 0; dc_ack_rdy = 1;
        #1 checkOutput("t6_after_ack_valid", dc_ack_valid, 1'b0);
        checkOutput("t6_after_mem_req_valid", mem_req_valid, 1'b0);
        mem_ack_valid = 0;
        ic_req_valid = 1; dc_req_valid = 1;
        #1 checkOutput("t6_tie_dc_wins", dc_req_rdy, 1'b1);
        checkOutput("t6_tie_ic_loses", ic_req_rdy, 1'b0);
        tick();
        ic_req_valid = 0; dc_req_valid = 0;
        checkOutput("t6_no_ack_delivered", 32'(dc_acks - acks_before), 32'd0);
        waitIdle("t6_drain");
        idleInputs();

        applyStimulus(3000);
        check_en = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
